iir_decim_out: RTL and testbench

Downstream consumer of the first-order IIR filter output. Takes one signed 16-bit filtered sample per enabled clock and average-decimates by a power-of-two factor with rounding, optional gain and saturation. Results are buffered in a small first-word-fall-through FIFO and presented on a valid/ready interface to the next rate domain.

---
 rtl/iir_decim_out.sv | 144 ++++++++++++++
 tb/tb_iir_decim_out.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_decim_out.sv
// sync_fifo: generic first-word-fall-through FIFO. dout shows the head with no read latency.
// The caller must not push when full without a pop in the same cycle, and must not pop when empty.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset; the occupancy count decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// iir_decim_out: averages 2^LOG2_DECIM IIR samples, then applies gain, rounding and saturation. The result enters the FWFT FIFO one edge after the last sample of the group.
// A result that finds the FIFO full, with no pop in the same cycle, is dropped and sets the sticky overflow flag.
module iir_decim_out #(
  parameter int DW         = 16,
  parameter int LOG2_DECIM = 2,
  parameter int GAIN_SH    = 0,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          x_in,
  input  logic                   x_en,
  input  logic                   flush,
  output logic [DW-1:0]          y_out,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overflow
);
  localparam int D  = 1 << LOG2_DECIM;
  localparam int AW = DW + LOG2_DECIM + 1;
  localparam int TW = AW + GAIN_SH + 1;
  localparam int PW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [PW-1:0]        PH_LAST = PW'(D - 1);
  localparam logic [CW-1:0]        FULL    = CW'(DEPTH);
  localparam logic signed [TW-1:0] RND     = TW'((1 << LOG2_DECIM) >> 1);
  localparam logic signed [TW-1:0] SAT_MAX = TW'((1 << (DW - 1)) - 1);
  localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] x_ext;
  logic [PW-1:0]        ph;
  logic                 dump;

  assign x_ext = {{(LOG2_DECIM + 1){x_in[DW-1]}}, x_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      ph   <= '0;
      dump <= 1'b0;
    end else if (flush) begin
      acc  <= '0;
      ph   <= '0;
      dump <= 1'b0;
    end else begin
      dump <= 1'b0;
      if (x_en) begin
        acc <= ((ph == '0) ? '0 : acc) + x_ext;
        if (ph == PH_LAST) begin
          ph   <= '0;
          dump <= 1'b1;
        end else begin
          ph <= ph + 1'b1;
        end
      end
    end
  end

  // The dump stage reads acc before it is overwritten by the next group's first sample.
  logic signed [TW-1:0] t_gain;
  logic signed [TW-1:0] t_rnd;
  logic [DW-1:0]        dump_dat;

  always_comb begin
    t_gain = TW'(acc) <<< GAIN_SH;
    t_rnd  = (t_gain + RND) >>> LOG2_DECIM;
    if (t_rnd > SAT_MAX)      dump_dat = SAT_MAX[DW-1:0];
    else if (t_rnd < SAT_MIN) dump_dat = SAT_MIN[DW-1:0];
    else                      dump_dat = t_rnd[DW-1:0];
  end

  logic          push_req;
  logic          push;
  logic          pop;
  logic [DW-1:0] head;

  assign y_valid  = (fifo_cnt != '0);
  assign pop      = y_valid & y_ready;
  assign push_req = dump & ~flush;
  assign push     = push_req & ((fifo_cnt < FULL) | pop);
  assign y_out    = y_valid ? head : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                overflow <= 1'b0;
    else if (push_req & ~push) overflow <= 1'b1;
  end

  sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (dump_dat),
    .dout  (head),
    .cnt   (fifo_cnt)
  );
endmodule

// File: tb/tb_iir_decim_out.sv
// Bench for iir_decim_out: table of group averages, hand-written corner sequences, and a randomized run against a queue model.
module tb_iir_decim_out;
  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] x_in;
  logic               x_en;
  logic               flush;
  logic               y_ready;
  logic signed [15:0] y_out, g_y_out;
  logic               y_valid, g_y_valid;
  logic [3:0]         fifo_cnt, g_fifo_cnt;
  logic               overflow, g_overflow;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  iir_decim_out #(.DW(16), .LOG2_DECIM(2), .GAIN_SH(0), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_en(x_en), .flush(flush),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .fifo_cnt(fifo_cnt), .overflow(overflow)
  );

  iir_decim_out #(.DW(16), .LOG2_DECIM(2), .GAIN_SH(2), .DEPTH(8)) dut_g (
    .clk(clk), .reset(reset), .x_in(x_in), .x_en(x_en), .flush(flush),
    .y_out(g_y_out), .y_valid(g_y_valid), .y_ready(y_ready),
    .fifo_cnt(g_fifo_cnt), .overflow(g_overflow)
  );

  typedef struct {
    int s0, s1, s2, s3;
    bit gain;
    int expv;
  } vec_t;

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Inputs are applied at the falling edge; outputs are checked at the next falling edge.
  task automatic cyc(input bit en, input int x, input bit fl, input bit rdy);
    x_en    = en;
    x_in    = 16'(x);
    flush   = fl;
    y_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send4(input int v, input bit rdy);
    for (int i = 0; i < 4; i++) cyc(1'b1, v, 1'b0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b0; x_en = 1'b0; flush = 1'b0; y_ready = 1'b0; x_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference: group sum divided by 4, rounding half toward +inf, saturated to 16 bits.
  function automatic int ref_out(input int sum);
    int v, q;
    v = sum + 2;
    q = (v >= 0) ? v / 4 : -((-v + 3) / 4);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  vec_t tv[10];

  initial begin
    tv[0] = '{100, 200, 300, 400, 1'b0, 250};
    tv[1] = '{-8, -8, -8, -8, 1'b0, -8};
    tv[2] = '{0, 0, 1, 1, 1'b0, 1};
    tv[3] = '{-1, -1, -1, -2, 1'b0, -1};
    tv[4] = '{1, 1, 2, 2, 1'b0, 2};
    tv[5] = '{-1, -1, 0, 0, 1'b0, 0};
    tv[6] = '{10000, 10000, 10000, 10000, 1'b1, 32767};
    tv[7] = '{-10000, -10000, -10000, -10000, 1'b1, -32768};
    tv[8] = '{8191, 8191, 8191, 8191, 1'b1, 32764};
    tv[9] = '{32767, -32768, 32767, -32768, 1'b0, 0};

    reset = 1'b0; x_en = 1'b0; flush = 1'b0; y_ready = 1'b0; x_in = '0;
    #1;
    chk("rst_valid", y_valid, 0);
    chk("rst_out", y_out, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_g_cnt", g_fifo_cnt, 0);
    chk("rst_g_ovf", g_overflow, 0);
    do_reset();

    // Group table: result must be visible exactly two edges after the 4th sample, for one cycle.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, tv[i].s0, 1'b0, 1'b1);
      cyc(1'b1, tv[i].s1, 1'b0, 1'b1);
      cyc(1'b1, tv[i].s2, 1'b0, 1'b1);
      cyc(1'b1, tv[i].s3, 1'b0, 1'b1);
      chk("tbl_early", tv[i].gain ? g_y_valid : y_valid, 0);
      cyc(1'b0, 0, 1'b0, 1'b1);
      chk("tbl_valid", tv[i].gain ? g_y_valid : y_valid, 1);
      chk("tbl_out", tv[i].gain ? int'(g_y_out) : int'(y_out), tv[i].expv);
      cyc(1'b0, 0, 1'b0, 1'b1);
      chk("tbl_popped", tv[i].gain ? g_y_valid : y_valid, 0);
    end

    // Backpressure: nine groups into an 8-deep FIFO.
    do_reset();
    for (int k = 1; k <= 9; k++) send4(k, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("bp_cnt", fifo_cnt, 8);
    chk("bp_ovf", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      chk("bp_valid", y_valid, 1);
      chk("bp_order", y_out, k);
      cyc(1'b0, 0, 1'b0, 1'b1);
    end
    chk("bp_empty_valid", y_valid, 0);
    chk("bp_empty_out", y_out, 0);
    chk("bp_empty_cnt", fifo_cnt, 0);

    // Push while full with a simultaneous pop.
    do_reset();
    for (int k = 1; k <= 8; k++) send4(k, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("full_cnt", fifo_cnt, 8);
    chk("full_ovf", overflow, 0);
    send4(50, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("fullpp_cnt", fifo_cnt, 8);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", y_out, 2);

    // Single entry popped on the same edge a new one lands.
    do_reset();
    send4(5, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("one_out", y_out, 5);
    send4(9, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("swap_valid", y_valid, 1);
    chk("swap_out", y_out, 9);
    chk("swap_cnt", fifo_cnt, 1);

    // Flush discards the partial group; gaps inside a group are allowed.
    do_reset();
    cyc(1'b1, 7, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 40, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0);
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("flush_cnt", fifo_cnt, 1);
    chk("flush_out", y_out, 40);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("flush_pop", fifo_cnt, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 3, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("flush4_cnt", fifo_cnt, 0);
    send4(20, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("flush_realign_cnt", fifo_cnt, 1);
    chk("flush_realign_out", y_out, 20);

    // Asynchronous reset in the middle of a group.
    do_reset();
    for (int k = 0; k < 3; k++) send4(5, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("pre_rst_cnt", fifo_cnt, 3);
    cyc(1'b1, 1, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", y_valid, 0);
    chk("arst_out", y_out, 0);
    chk("arst_cnt", fifo_cnt, 0);
    chk("arst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    send4(12, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("post_rst_cnt", fifo_cnt, 1);
    chk("post_rst_out", y_out, 12);

    // Randomized run against a group-sum / queue model.
    do_reset();
    begin
      int  q[$];
      int  ph_m = 0, sum_m = 0, pend_v = 0, exp_out, x, rdy_pct;
      bit  pend = 1'b0, ovf_m = 1'b0, en, fl, rdy;
      for (int i = 0; i < 1500; i++) begin
        exp_out = 0;
        if (q.size() > 0) exp_out = q[0];
        chk("rnd_valid", y_valid, int'(q.size() > 0));
        chk("rnd_out", y_out, exp_out);
        chk("rnd_cnt", fifo_cnt, q.size());
        chk("rnd_ovf", overflow, ovf_m);

        rdy_pct = (i < 500) ? 90 : (i < 1000) ? 25 : 70;
        en  = ($urandom_range(0, 99) < 80);
        fl  = ($urandom_range(0, 99) < 3);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 1) == 1) x = int'($urandom_range(0, 65535)) - 32768;
        else                           x = int'($urandom_range(0, 40)) - 20;

        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (pend && !fl) begin
          if (q.size() < 8) q.push_back(pend_v);
          else              ovf_m = 1'b1;
        end
        pend = 1'b0;
        if (fl) begin
          ph_m = 0;
          sum_m = 0;
        end else if (en) begin
          sum_m += x;
          ph_m++;
          if (ph_m == 4) begin
            pend   = 1'b1;
            pend_v = ref_out(sum_m);
            ph_m   = 0;
            sum_m  = 0;
          end
        end
        cyc(en, x, fl, rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
